fifo_fwft: RTL

Parametrised first-word-fall-through FIFO with valid/ready handshakes on both sides, an exact occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It supersedes the plain enqueue/dequeue queue for streaming paths between pixel-pipeline stages. Storage is the team's single-port-write, synchronous-read dual-address RAM. A small output stage hides the RAM read latency, so the head word is always presented without a request.

---
 rtl/fifo_fwft.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: sync-read RAM, prefetch register and output register.
// Define FIFO_HWM_EN to add the hwm (peak level) port.
module fifo_fwft #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FIFO_HWM_EN
  ,
  output logic [ADDR_WIDTH:0]   hwm
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_L    = AFULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_L   = AEMPTY_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  mid_valid;
  logic [DATA_WIDTH-1:0] mid_data;
  logic                  push, pop, out_load, mid_load, clear;
  logic [ADDR_WIDTH:0]   ram_words, level_next;

  assign clear    = reset || flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_load = mid_valid && (!out_valid || pop);
  // Words still sitting in the RAM, not yet pulled into either register stage.
  assign ram_words = level - {{ADDR_WIDTH{1'b0}}, out_valid} - {{ADDR_WIDTH{1'b0}}, mid_valid};
  assign mid_load  = (ram_words != '0) && (!mid_valid || out_load);

  always_comb begin
    level_next = level;
    if (clear) begin
      level_next = '0;
    end else if (push && !pop) begin
      level_next = level + (ADDR_WIDTH+1)'(1);
    end else if (pop && !push) begin
      level_next = level - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Data registers carry no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (mid_load) begin
      mid_data <= mem[rd_ptr];
    end
    if (out_load) begin
      out_data <= mid_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (mid_load) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      mid_valid <= mid_load || (mid_valid && !out_load);
      out_valid <= out_load || (out_valid && !pop);
    end
    level        <= level_next;
    in_ready     <= (level_next != FULL_LEVEL);
    almost_full  <= (level_next >= AFULL_L);
    almost_empty <= (level_next <= AEMPTY_L);
  end

`ifdef FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      hwm <= '0;
    end else if (level_next > hwm) begin
      hwm <= level_next;
    end
  end
`endif

endmodule
